// File: rtl/addsub_issue_queue.sv
// Generic FIFO, then the issue/return queue around the registered 8-bit add/sub unit.
// Issue: earliest one cycle after a command is accepted; result visible three edges after acceptance.
// Backpressure: cmd_ready depends only on registered command occupancy; issue waits for return credit.

// Small synchronous FIFO with an occupancy count; any depth >= 1.
// Latency: a pushed word is visible at dout on the edge after the push.
// Backpressure: none internally; the caller must never push when full unless it pops in the same cycle.
module addsub_iq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Write the tail, advance pointers with explicit wrap, and track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Storage and pointer registers; storage is cleared so an empty head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// Command queue feeding the external registered adder, with tagged in-order result return.
// Latency: accept at edge A, issue at A+1, adder result at A+2, res_valid after A+3.
// Backpressure: issue only when the return FIFO has room for everything in flight plus one.
module addsub_issue_queue #(
    parameter int WIDTH     = 8,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int ID_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_add_sub,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_add_sub,
    input  logic [WIDTH-1:0] op_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [ID_W-1:0]  res_id,
    output logic             busy
);
    localparam int CMD_W = 2 * WIDTH + 1;
    localparam int RES_W = WIDTH + ID_W;
    localparam int CCW   = $clog2(CMD_DEPTH + 1);
    localparam int RCW   = $clog2(RES_DEPTH + 1);
    localparam int NW    = RCW + 2;

    logic [CCW-1:0]   cmd_count;
    logic [CMD_W-1:0] cmd_head;
    logic             cmd_push;
    logic [RCW-1:0]   res_count;
    logic [RES_W-1:0] res_head;
    logic             res_pop;
    logic [NW-1:0]    res_need;
    logic             issue;

    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_add_sub_q, op_add_sub_d;
    logic             iss_v_q, iss_v_d;
    logic [ID_W-1:0]  iss_tag_q, iss_tag_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             ret_v_q, ret_v_d;
    logic [ID_W-1:0]  ret_tag_q, ret_tag_d;

    assign cmd_ready = (cmd_count != CCW'(CMD_DEPTH));
    assign cmd_push  = cmd_valid & cmd_ready;
    assign res_valid = (res_count != '0);
    assign res_pop   = res_valid & res_ready;

    addsub_iq_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_push),
        .din   ({cmd_a, cmd_b, cmd_add_sub}),
        .pop   (issue),
        .dout  (cmd_head),
        .count (cmd_count)
    );

    // Credit check: slots held by the return FIFO and both pipeline stages, minus a pop, plus this issue.
    always_comb begin
        res_need = NW'(res_count) + NW'(iss_v_q) + NW'(ret_v_q) + NW'(1) - NW'(res_pop);
        issue    = (cmd_count != '0) && (res_need <= NW'(RES_DEPTH));
    end

    // Issue stage loads the adder operands and tags; the return stage mirrors the adder's one-cycle delay.
    always_comb begin
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_add_sub_d = op_add_sub_q;
        iss_tag_d    = iss_tag_q;
        id_d         = id_q;
        iss_v_d      = issue;
        ret_v_d      = iss_v_q;
        ret_tag_d    = iss_tag_q;
        if (issue) begin
            op_a_d       = cmd_head[CMD_W-1 -: WIDTH];
            op_b_d       = cmd_head[WIDTH:1];
            op_add_sub_d = cmd_head[0];
            iss_tag_d    = id_q;
            id_d         = id_q + 1'b1;
        end
    end

    // Pipeline registers; reset drops everything in flight and restarts the ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_add_sub_q <= 1'b0;
            iss_v_q      <= 1'b0;
            iss_tag_q    <= '0;
            id_q         <= '0;
            ret_v_q      <= 1'b0;
            ret_tag_q    <= '0;
        end else begin
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_add_sub_q <= op_add_sub_d;
            iss_v_q      <= iss_v_d;
            iss_tag_q    <= iss_tag_d;
            id_q         <= id_d;
            ret_v_q      <= ret_v_d;
            ret_tag_q    <= ret_tag_d;
        end
    end

    // Capture the adder output only when the return stage holds a real command.
    addsub_iq_fifo #(.W(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ret_v_q),
        .din   ({op_result, ret_tag_q}),
        .pop   (res_pop),
        .dout  (res_head),
        .count (res_count)
    );

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_add_sub = op_add_sub_q;
    assign res_data   = res_head[RES_W-1 -: WIDTH];
    assign res_id     = res_head[ID_W-1:0];
    assign busy       = (cmd_count != '0) | iss_v_q | ret_v_q | res_valid;
endmodule

// File: tb/tb_addsub_issue_queue.sv
module tb_addsub_issue_queue;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic       cmd_add_sub = 1'b0;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_add_sub;
    logic [7:0] op_result;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic [3:0] res_id;
    logic       busy;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] d;
        logic [3:0] id;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] next_id = '0;

    always #5 clk = ~clk;

    // External registered adder: no reset, result one edge after its inputs.
    logic [7:0] adder_q;
    always @(posedge clk) adder_q <= op_add_sub ? (op_a + op_b) : (op_a - op_b);
    assign op_result = adder_q;

    addsub_issue_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_add_sub (cmd_add_sub),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_add_sub  (op_add_sub),
        .op_result   (op_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_id      (res_id),
        .busy        (busy)
    );

    function automatic exp_t pop_exp();
        exp_t e;
        e.d  = 'x;
        e.id = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        return e;
    endfunction

    // One clock: drive at negedge, sample handshakes, let the edge happen, return just after it.
    // Every accepted command enters the model with its arithmetic result and the next sequence ID.
    task automatic step(input logic cv, input logic [7:0] a, input logic [7:0] b, input logic as,
                        input logic rr, output logic cf, output logic rf,
                        output logic [7:0] rd, output logic [3:0] rid);
        exp_t e;
        @(negedge clk);
        cmd_valid   = cv;
        cmd_a       = a;
        cmd_b       = b;
        cmd_add_sub = as;
        res_ready   = rr;
        #1;
        cf  = cv & cmd_ready;
        rf  = res_valid & rr;
        rd  = res_data;
        rid = res_id;
        if (cf) begin
            e.d  = as ? 8'(a + b) : 8'(a - b);
            e.id = next_id;
            next_id = next_id + 1'b1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        exp_q.delete();
        next_id = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({cmd_ready, res_valid, busy, op_add_sub} !== 4'b1000)
            $display("FAIL reset_ctrl got ready/valid/busy/addsub=%b want 1000",
                     {cmd_ready, res_valid, busy, op_add_sub});
        else passed++;
        total++;
        if ({res_data, res_id, op_a, op_b} !== 28'h0)
            $display("FAIL reset_data got data=%h id=%h op_a=%h op_b=%h want all 0",
                     res_data, res_id, op_a, op_b);
        else passed++;
    endtask

    task automatic test_single_add();
        logic cf, rf;
        logic [7:0] rd;
        logic [3:0] rid;
        exp_t e;
        do_reset();
        step(1, 8'h12, 8'h34, 1, 1, cf, rf, rd, rid);   // edge 0
        step(0, 0, 0, 0, 1, cf, rf, rd, rid);           // edge 1
        total++;
        if ({op_a, op_add_sub} !== {8'h12, 1'b1})
            $display("FAIL single_issue got op_a=%h add_sub=%b want 12 1", op_a, op_add_sub);
        else passed++;
        step(0, 0, 0, 0, 1, cf, rf, rd, rid);           // edge 2
        total++;
        if (res_valid !== 1'b0) $display("FAIL single_early got res_valid=%b want 0", res_valid);
        else passed++;
        step(0, 0, 0, 0, 1, cf, rf, rd, rid);           // edge 3
        total++;
        if (res_valid !== 1'b1) $display("FAIL single_latency got res_valid=%b want 1", res_valid);
        else passed++;
        step(0, 0, 0, 0, 1, cf, rf, rd, rid);           // pop
        e = pop_exp();
        total++;
        if ({rf, rd, rid} !== {1'b1, 8'h46, 4'h0})
            $display("FAIL single_result got fire=%b data=%h id=%h want 1 46 0", rf, rd, rid);
        else passed++;
        total++;
        if ({rd, rid} !== {e.d, e.id})
            $display("FAIL single_model got data=%h id=%h want %h %h", rd, rid, e.d, e.id);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL single_busy got busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_wrap();
        logic cf, rf;
        logic [7:0] rd;
        logic [3:0] rid;
        logic [7:0] want_d [2];
        int n;
        want_d[0] = 8'h10;
        want_d[1] = 8'hFB;
        n = 0;
        do_reset();
        step(1, 8'hF0, 8'h20, 1, 1, cf, rf, rd, rid);
        step(1, 8'h05, 8'h0A, 0, 1, cf, rf, rd, rid);
        for (int s = 0; s < 20; s++) begin
            step(0, 0, 0, 0, 1, cf, rf, rd, rid);
            if (rf) begin
                void'(pop_exp());
                total++;
                if (n > 1 || {rd, rid} !== {want_d[n], 4'(n)})
                    $display("FAIL wrap_result[%0d] got data=%h id=%h", n, rd, rid);
                else passed++;
                n++;
            end
        end
        total++;
        if (n !== 2) $display("FAIL wrap_count got %0d results want 2", n);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic cf, rf;
        logic [7:0] rd;
        logic [3:0] rid;
        exp_t e;
        int nres, nacc;
        nres = 0;
        nacc = 0;
        do_reset();
        for (int s = 0; s < 40; s++) begin
            step(s < 20, 8'($urandom), 8'($urandom), 1'($urandom), 1, cf, rf, rd, rid);
            if (cf) nacc++;
            if (rf) begin
                e = pop_exp();
                total++;
                if ({rd, rid} !== {e.d, e.id} || s != nres + 4)
                    $display("FAIL b2b_result[%0d] got data=%h id=%h step=%0d want %h %h step=%0d",
                             nres, rd, rid, s, e.d, e.id, nres + 4);
                else passed++;
                nres++;
            end
        end
        total++;
        if (nacc !== 20 || nres !== 20)
            $display("FAIL b2b_count got accepted=%0d results=%0d want 20 20", nacc, nres);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic cf, rf;
        logic [7:0] rd;
        logic [3:0] rid;
        exp_t e;
        int nacc, nres;
        nacc = 0;
        nres = 0;
        do_reset();
        for (int s = 0; s < 16; s++) begin
            step(1, 8'($urandom), 8'($urandom), 1'($urandom), 0, cf, rf, rd, rid);
            if (cf) nacc++;
        end
        total++;
        if ({nacc, cmd_ready, res_valid, busy} !== {32'd8, 3'b011})
            $display("FAIL bp_fill got accepted=%0d ready=%b valid=%b busy=%b want 8 0 1 1",
                     nacc, cmd_ready, res_valid, busy);
        else passed++;
        for (int s = 0; s < 40; s++) begin
            step(0, 0, 0, 0, 1, cf, rf, rd, rid);
            if (rf) begin
                e = pop_exp();
                total++;
                if ({rd, rid} !== {e.d, e.id})
                    $display("FAIL bp_result[%0d] got data=%h id=%h want %h %h",
                             nres, rd, rid, e.d, e.id);
                else passed++;
                nres++;
            end
        end
        total++;
        if (nres !== 8 || busy !== 1'b0)
            $display("FAIL bp_drain got results=%0d busy=%b want 8 0", nres, busy);
        else passed++;
    endtask

    task automatic test_random();
        logic cf, rf;
        logic [7:0] rd;
        logic [3:0] rid;
        exp_t e;
        int nacc, nres, errs, full_viol, max_out;
        nacc = 0;
        nres = 0;
        errs = 0;
        full_viol = 0;
        max_out = 0;
        do_reset();
        for (int s = 0; s < 20000 && nres < 1000; s++) begin
            step((nacc < 1000) && ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                 1'($urandom), $urandom_range(0, 9) < 6, cf, rf, rd, rid);
            if (cf) nacc++;
            if (rf) begin
                e = pop_exp();
                total++;
                if ({rd, rid} !== {e.d, e.id}) begin
                    $display("FAIL rand_result[%0d] got data=%h id=%h want %h %h",
                             nres, rd, rid, e.d, e.id);
                    errs++;
                end else passed++;
                nres++;
            end
            if (exp_q.size() > max_out) max_out = exp_q.size();
            if (exp_q.size() == 8 && cmd_ready !== 1'b0) full_viol++;
        end
        total++;
        if (nres !== 1000 || exp_q.size() !== 0)
            $display("FAIL rand_count got results=%0d leftover=%0d want 1000 0", nres, exp_q.size());
        else passed++;
        total++;
        if (full_viol !== 0 || max_out > 8)
            $display("FAIL rand_ready got full_ready=%0d max_outstanding=%0d want 0 <=8",
                     full_viol, max_out);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic cf, rf;
        logic [7:0] rd;
        logic [3:0] rid;
        exp_t e;
        int nres, stale;
        nres = 0;
        stale = 0;
        do_reset();
        for (int s = 0; s < 4; s++) step(1, 8'(s + 1), 8'h11, 1, 0, cf, rf, rd, rid);
        step(0, 0, 0, 0, 0, cf, rf, rd, rid);
        total++;
        if ({res_valid, busy} !== 2'b11)
            $display("FAIL mid_setup got valid=%b busy=%b want 1 1", res_valid, busy);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({cmd_ready, res_valid, busy, op_add_sub, res_data, res_id, op_a, op_b} !== {4'b1000, 28'h0})
            $display("FAIL mid_reset got ready=%b valid=%b busy=%b addsub=%b data=%h id=%h op_a=%h op_b=%h",
                     cmd_ready, res_valid, busy, op_add_sub, res_data, res_id, op_a, op_b);
        else passed++;
        exp_q.delete();
        next_id = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 6; s++) begin
            step(0, 0, 0, 0, 1, cf, rf, rd, rid);
            if (rf) stale++;
        end
        total++;
        if (stale !== 0) $display("FAIL mid_stale got %0d stale results want 0", stale);
        else passed++;
        step(1, 8'h40, 8'h01, 0, 1, cf, rf, rd, rid);
        for (int s = 0; s < 10; s++) begin
            step(0, 0, 0, 0, 1, cf, rf, rd, rid);
            if (rf) begin
                e = pop_exp();
                total++;
                if ({rd, rid} !== {8'h3F, 4'h0} || {rd, rid} !== {e.d, e.id})
                    $display("FAIL mid_next got data=%h id=%h want 3f 0", rd, rid);
                else passed++;
                nres++;
            end
        end
        total++;
        if (nres !== 1) $display("FAIL mid_count got %0d results want 1", nres);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/addsub_issue_queue.md
Name: addsub_issue_queue

Overview:
- Upstream issue/return stage for the registered 8-bit add/subtract unit. It drives that unit's dataa, datab and add_sub inputs and consumes its result output.
- Accepts operation commands over valid/ready and queues them in a command FIFO.
- Issues at most one command per cycle to the adder, tracks its fixed 1-cycle result latency, and captures each result into a return FIFO.
- Presents results downstream over valid/ready, tagged with a sequence ID, with credit-based issue so no result is ever lost.

Parameters:
WIDTH, 8, operand/result width; must match the adder.
CMD_DEPTH, 4, command FIFO entries, power of 2, >=2.
RES_DEPTH, 4, return FIFO entries, >=1; >=3 gives full throughput under a ready sink.
ID_W, 4, sequence ID width.

Ports:
clk  in  1  rising-edge clock, shared with the adder.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  command FIFO not full.
cmd_a  in  WIDTH  operand A.
cmd_b  in  WIDTH  operand B.
cmd_add_sub  in  1  1 = add, 0 = subtract.
op_a  out  WIDTH  to adder dataa.
op_b  out  WIDTH  to adder datab.
op_add_sub  out  1  to adder add_sub.
op_result  in  WIDTH  from adder result.
res_valid  out  1  return FIFO not empty.
res_ready  in  1  sink accepts result.
res_data  out  WIDTH  result at return FIFO head.
res_id  out  ID_W  sequence ID of res_data.
busy  out  1  any command queued, in flight, or result pending.

Behaviour:
- Reset (async assert, sync release): both FIFOs emptied; op_a = op_b = 0; op_add_sub = 0; iss_v = ret_v = 0; issue ID = 0; res_valid = 0; res_data = 0; res_id = 0; busy = 0; cmd_ready = 1.
- Push: cmd_valid & cmd_ready at an edge writes {a, b, add_sub}. cmd_ready = (cmd_count < CMD_DEPTH), from registered state only. No combinational path from the res_* signals.
- Issue condition: cmd FIFO not empty AND res_count + iss_v + ret_v - res_pop + 1 <= RES_DEPTH, where res_pop = res_valid & res_ready.
- Issue action: pop the head into op_a, op_b and op_add_sub; set iss_v = 1; tag the command with the issue ID; increment the ID mod 2^ID_W.
- Idle cycles: iss_v = 0; op_* hold their previous values.
- Pipeline, one issued command per stage:
  - Edge E0: op_* loaded, iss_v = 1.
  - Edge E1: adder registers its result; ret_v <= iss_v; tag moves with ret_v.
  - Edge E2: if ret_v, {op_result, tag} is written into the return FIFO.
- Latency: command accepted at edge A into an empty FIFO; earliest issue at A+1; res_valid high after A+3.
- Throughput: 1 result/cycle when RES_DEPTH >= 3 and res_ready is held high.
- Arithmetic is the adder's own: result = A + B or A - B mod 2^WIDTH, with no carry or borrow flag. This block never alters the data.
- Ordering: results are returned strictly in command order; res_id increments by 1 mod 2^ID_W per result.
- Return FIFO write and pop in the same cycle are legal, including when it is full (credit rules guarantee it never overflows). Command FIFO push and issue in the same cycle are legal.
- ret_v = 0 in a cycle means op_result is ignored. This covers the adder's unreset output after rst_n.
- Reset mid-operation discards all queued, in-flight and pending items. The ID restarts at 0.
- busy = (cmd_count != 0) | iss_v | ret_v | res_valid.

Test Plan:
- Single add: push {a=0x12, b=0x34, add} at edge 0, res_ready = 1 -> op_a = 0x12 after edge 1; res_valid after edge 3 with res_data = 0x46, res_id = 0; busy low after the pop.
- Wrap/underflow: push {0xF0, 0x20, add} then {0x05, 0x0A, sub} -> results 0x10 (id 0) then 0xFB (id 1).
- Back-to-back stream: 20 random commands, cmd_valid and res_ready held high -> after a 3-cycle fill, one result per cycle; all 20 match the model; ids 0..15, 0..3.
- Backpressure: res_ready = 0, push 8 commands -> return FIFO fills to 4 and issue stalls; cmd FIFO fills; cmd_ready drops. Raise res_ready -> all 8 results delivered in order, none lost or duplicated.
- Random valid/ready toggling, 1000 commands -> scoreboard matches in order; cmd_ready never high when the FIFO is full.
- Reset mid-stream: assert rst_n = 0 with 2 commands in flight and 2 results pending -> all outputs are at reset values immediately. After release, no stale result appears, and the next result has id 0.
